// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage and its neighbours: the instruction memory port, the
// redirect from execute, and the decode handshake with status.
interface fetch_unit_if #(
    parameter int QUEUE_DEPTH = 2
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [31:0]   imem_addr;
    logic [31:0]   imem_data;
    logic          redirect_valid;
    logic [31:0]   redirect_target;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [31:0]   out_pc;
    logic          fetch_err;
    logic [CW-1:0] queue_count;

    modport master (
        output imem_addr, out_valid, out_inst, out_pc, fetch_err, queue_count,
        input  imem_data, redirect_valid, redirect_target, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_inst, out_pc, fetch_err, queue_count,
        output imem_data, redirect_valid, redirect_target, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a combinational instruction memory and
// buffers {pc, inst} pairs in a small circular queue feeding decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int              PW      = $clog2(QUEUE_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(QUEUE_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic [31:0]   pc;
    entry_t        mem [QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          err;

    logic          pop;
    logic          push;
    logic          misaligned;
    entry_t        head;

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        pop        = 1'b0;
        push       = 1'b0;
        misaligned = 1'b0;
        head       = mem[rd_ptr];
        pop        = (count != '0) && bus.out_ready;
        push       = !err && !bus.redirect_valid && ((count < DEPTH_C) || pop);
        misaligned = bus.redirect_target[1:0] != 2'b00;
    end

    assign bus.imem_addr   = pc;
    assign bus.out_valid   = (count != '0);
    assign bus.out_inst    = (count != '0) ? head.inst : 32'h0;
    assign bus.out_pc      = (count != '0) ? head.pc   : 32'h0;
    assign bus.fetch_err   = err;
    assign bus.queue_count = count;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Redirect wins over push and pop; decode's handshake this cycle is dropped.
            pc     <= bus.redirect_target;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (misaligned) begin
                err <= 1'b1;
            end
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage has no reset; stale entries are never visible because the
    // outputs are gated by the occupancy counter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: pc, inst: bus.imem_data};
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked against a
// queue-based model of the fetch stage.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QD       = 2;
    localparam int          CW       = $clog2(QD) + 1;

    logic clk;
    logic rst_n;
    bit   const_mode;
    int   errors;
    int   checks;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_err;

    fetch_unit_if #(.QUEUE_DEPTH(QD)) bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(QD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] a);
        return const_mode ? 32'h0000_0013 : inst_of(a);
    endfunction

    always_comb bus.imem_data = exp_inst(bus.imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: one call per rising edge with the inputs applied for that edge.
    task automatic model_edge();
        ent_t e;
        if (bus.redirect_valid) begin
            mq.delete();
            m_pc = bus.redirect_target;
            if (bus.redirect_target[1:0] != 2'b00) m_err = 1'b1;
        end else begin
            if (mq.size() != 0 && bus.out_ready) mq.delete(0);
            if (!m_err && mq.size() < QD) begin
                e.pc   = m_pc;
                e.inst = exp_inst(m_pc);
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.out_ready       = 1'b0;
        mq.delete();
        m_pc  = RESET_PC;
        m_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        const_mode = 1'b1;
        do_reset();
        checks += 6;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        if (bus.queue_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.queue_count); end
        if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.out_pc); end
        if (bus.out_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", bus.out_inst); end
        if (bus.fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.fetch_err); end
        if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h expected %h", bus.imem_addr, RESET_PC); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 3;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            if (bus.out_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, bus.out_pc, 32'(4 * i)); end
            if (bus.out_inst !== 32'h13) begin errors++; $display("FAIL stream_inst[%0d]: got %h expected 00000013", i, bus.out_inst); end
        end
    endtask

    task automatic test_backpressure();
        const_mode = 1'b0;
        do_reset();
        repeat (5) tick();
        checks += 3;
        if (bus.queue_count !== CW'(2)) begin errors++; $display("FAIL bp_count: got %0d expected 2", bus.queue_count); end
        if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL bp_pc_hold: got %h expected 00000008", bus.imem_addr); end
        if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got %h expected 0", bus.out_pc); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks += 3;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            if (bus.out_pc !== 32'(4 * i)) begin errors++; $display("FAIL bp_pc[%0d]: got %h expected %h", i, bus.out_pc, 32'(4 * i)); end
            if (bus.out_inst !== inst_of(32'(4 * i))) begin errors++; $display("FAIL bp_inst[%0d]: got %h expected %h", i, bus.out_inst, inst_of(32'(4 * i))); end
            tick();
        end
    endtask

    task automatic test_redirect();
        const_mode = 1'b0;
        do_reset();
        bus.out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.out_pc !== 32'h4) begin errors++; $display("FAIL redir_pre: got %h expected 00000004", bus.out_pc); end
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid: got %b expected 0", bus.out_valid); end
        if (bus.queue_count !== '0) begin errors++; $display("FAIL redir_flush_count: got %0d expected 0", bus.queue_count); end
        if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr: got %h expected 00000100", bus.imem_addr); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks += 2;
            if (bus.out_pc !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL redir_pc[%0d]: got %h expected %h", i, bus.out_pc, 32'h100 + 32'(4 * i)); end
            if (bus.out_inst !== inst_of(32'h100 + 32'(4 * i))) begin errors++; $display("FAIL redir_inst[%0d]: got %h", i, bus.out_inst); end
        end
    endtask

    task automatic test_misaligned();
        const_mode = 1'b0;
        do_reset();
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h102;
        tick();
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.fetch_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", bus.fetch_err); end
        for (int i = 0; i < 10; i++) begin
            checks += 2;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mis_valid[%0d]: got %b expected 0", i, bus.out_valid); end
            if (bus.imem_addr !== 32'h102) begin errors++; $display("FAIL mis_pc_hold[%0d]: got %h expected 00000102", i, bus.imem_addr); end
            tick();
        end
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h200;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        checks += 3;
        if (bus.fetch_err !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b expected 1", bus.fetch_err); end
        if (bus.imem_addr !== 32'h200) begin errors++; $display("FAIL mis_redir_pc: got %h expected 00000200", bus.imem_addr); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mis_valid_after: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp;
        const_mode = 1'b0;
        do_reset();
        bus.out_ready       = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'hFFFF_FFF8;
        tick();
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %b expected 0", bus.out_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = 32'hFFFF_FFF8 + 32'(4 * i);
            checks++;
            if (bus.out_pc !== exp) begin errors++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, bus.out_pc, exp); end
        end
    endtask

    task automatic test_back_to_back();
        const_mode = 1'b0;
        do_reset();
        bus.out_ready = 1'b1;
        tick();
        for (int k = 1; k <= 3; k++) begin
            bus.redirect_valid  = 1'b1;
            bus.redirect_target = 32'(k * 32'h40);
            tick();
            checks += 2;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 0", k, bus.out_valid); end
            if (bus.imem_addr !== 32'(k * 32'h40)) begin errors++; $display("FAIL b2b_pc[%0d]: got %h expected %h", k, bus.imem_addr, 32'(k * 32'h40)); end
        end
        bus.redirect_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_pc !== 32'hC0) begin errors++; $display("FAIL b2b_last: got %h expected 000000c0", bus.out_pc); end
    endtask

    task automatic test_async_reset();
        const_mode = 1'b0;
        do_reset();
        repeat (3) tick();
        checks++;
        if (bus.queue_count !== CW'(2)) begin errors++; $display("FAIL areset_pre: got %0d expected 2", bus.queue_count); end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", bus.out_valid); end
        if (bus.queue_count !== '0) begin errors++; $display("FAIL areset_count: got %0d expected 0", bus.queue_count); end
        if (bus.out_pc !== 32'h0 || bus.out_inst !== 32'h0) begin errors++; $display("FAIL areset_out: got pc=%h inst=%h expected 0", bus.out_pc, bus.out_inst); end
        if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL areset_addr: got %h expected %h", bus.imem_addr, RESET_PC); end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_pc  = RESET_PC;
        m_err = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks += 2;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL areset_resume_valid: got %b expected 1", bus.out_valid); end
        if (bus.out_pc !== RESET_PC) begin errors++; $display("FAIL areset_resume_pc: got %h expected %h", bus.out_pc, RESET_PC); end
    endtask

    task automatic test_random();
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        logic [31:0] tgt;
        const_mode = 1'b0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (m_err && ($urandom % 6) == 0) do_reset();
            ev  = (mq.size() != 0);
            epc = ev ? mq[0].pc : 32'h0;
            ein = ev ? mq[0].inst : 32'h0;
            checks += 6;
            if (bus.out_valid !== ev) begin errors++; $display("FAIL rand_valid c=%0d: got %b expected %b", c, bus.out_valid, ev); end
            if (bus.out_pc !== epc) begin errors++; $display("FAIL rand_pc c=%0d: got %h expected %h", c, bus.out_pc, epc); end
            if (bus.out_inst !== ein) begin errors++; $display("FAIL rand_inst c=%0d: got %h expected %h", c, bus.out_inst, ein); end
            if (bus.queue_count !== CW'(mq.size())) begin errors++; $display("FAIL rand_count c=%0d: got %0d expected %0d", c, bus.queue_count, mq.size()); end
            if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL rand_addr c=%0d: got %h expected %h", c, bus.imem_addr, m_pc); end
            if (bus.fetch_err !== m_err) begin errors++; $display("FAIL rand_err c=%0d: got %b expected %b", c, bus.fetch_err, m_err); end
            tgt = $urandom;
            if (($urandom % 16) != 0) tgt[1:0] = 2'b00;
            bus.redirect_valid  = (($urandom % 8) == 0);
            bus.redirect_target = tgt;
            bus.out_ready       = $urandom_range(0, 1) == 1;
            tick();
        end
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        const_mode = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.out_ready       = 1'b0;
        @(negedge clk);
        test_reset();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_pc_wrap();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
